// File: rtl/alu.sv
// 8-bit 6502-style arithmetic/logic unit for the NES CPU datapath.
// Combinational operand conditioning and flag generation feed a single
// registered stage that holds the result, the updated status byte and a
// one-cycle done strobe used by the top level to write the STAT register.
module alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,     // active-high asynchronous reset
    input  logic [7:0]       func,
    input  logic [WIDTH-1:0] status_in,
    input  logic             carry_in,
    input  logic             invert,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] dout,
    output logic             wout,
    output logic [WIDTH-1:0] status_out
);

    // Operation codes issued by the decoder.
    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_AND  = 8'h02;
    localparam logic [7:0] OP_OR   = 8'h03;
    localparam logic [7:0] OP_XOR  = 8'h04;
    localparam logic [7:0] OP_ASL  = 8'h05;
    localparam logic [7:0] OP_LSR  = 8'h06;
    localparam logic [7:0] OP_ROL  = 8'h07;
    localparam logic [7:0] OP_ROR  = 8'h08;
    localparam logic [7:0] OP_INC  = 8'h09;
    localparam logic [7:0] OP_DEC  = 8'h0A;
    localparam logic [7:0] OP_CMP  = 8'h0B;
    localparam logic [7:0] OP_BIT  = 8'h0C;
    localparam logic [7:0] OP_PASS = 8'h0D;

    // Status bit positions.
    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 6;
    localparam int FLAG_N = 7;

    // Zero flag helper.
    function automatic logic zero_flag(input logic [7:0] value);
        zero_flag = (value == 8'h00);
    endfunction

    // Replace only Z and N, leaving every other status bit as supplied.
    function automatic logic [7:0] set_zn(input logic [7:0] st, input logic [7:0] value);
        logic [7:0] tmp;
        tmp         = st;
        tmp[FLAG_Z] = zero_flag(value);
        tmp[FLAG_N] = value[7];
        set_zn      = tmp;
    endfunction

    // Signed overflow of an addition: like-signed operands, differently signed result.
    function automatic logic add_overflow(input logic [7:0] x, input logic [7:0] y,
                                          input logic [7:0] r);
        add_overflow = (x[7] == y[7]) && (r[7] != x[7]);
    endfunction

    logic [7:0] b_s;          // conditioned B operand (possibly inverted)
    logic       cin_s;        // adder carry in
    logic [8:0] sum_s;        // ADD result including carry out
    logic [8:0] diff_s;       // CMP difference a - b_in (carry out = no borrow)
    logic [7:0] res_s;        // next result
    logic [7:0] flags_s;      // next status
    logic       valid_s;      // func is a defined, executing operation

    logic [7:0] dout_r;
    logic [7:0] status_r;
    logic       wout_r;

    // Operand B, carry-in conditioning and the two arithmetic paths.
    always_comb begin
        b_s    = invert ? ~b_in : b_in;
        cin_s  = carry_in ? status_in[FLAG_C] : invert;
        sum_s  = {1'b0, a_in} + {1'b0, b_s} + {8'h00, cin_s};
        diff_s = {1'b0, a_in} + {1'b0, ~b_in} + 9'h001;
    end

    // Operation decode: result, new flags and whether the op executes.
    always_comb begin
        res_s   = 8'h00;
        flags_s = status_in;
        valid_s = 1'b1;
        case (func)
            OP_ADD: begin
                res_s           = sum_s[7:0];
                flags_s         = set_zn(status_in, sum_s[7:0]);
                flags_s[FLAG_C] = sum_s[8];
                flags_s[FLAG_V] = add_overflow(a_in, b_s, sum_s[7:0]);
            end
            OP_AND: begin
                res_s   = a_in & b_in;
                flags_s = set_zn(status_in, a_in & b_in);
            end
            OP_OR: begin
                res_s   = a_in | b_in;
                flags_s = set_zn(status_in, a_in | b_in);
            end
            OP_XOR: begin
                res_s   = a_in ^ b_in;
                flags_s = set_zn(status_in, a_in ^ b_in);
            end
            OP_ASL: begin
                res_s           = {a_in[6:0], 1'b0};
                flags_s         = set_zn(status_in, {a_in[6:0], 1'b0});
                flags_s[FLAG_C] = a_in[7];
            end
            OP_LSR: begin
                res_s           = {1'b0, a_in[7:1]};
                flags_s         = set_zn(status_in, {1'b0, a_in[7:1]});
                flags_s[FLAG_C] = a_in[0];
                flags_s[FLAG_N] = 1'b0;
            end
            OP_ROL: begin
                res_s           = {a_in[6:0], status_in[FLAG_C]};
                flags_s         = set_zn(status_in, {a_in[6:0], status_in[FLAG_C]});
                flags_s[FLAG_C] = a_in[7];
            end
            OP_ROR: begin
                res_s           = {status_in[FLAG_C], a_in[7:1]};
                flags_s         = set_zn(status_in, {status_in[FLAG_C], a_in[7:1]});
                flags_s[FLAG_C] = a_in[0];
            end
            OP_INC: begin
                res_s   = a_in + 8'h01;
                flags_s = set_zn(status_in, a_in + 8'h01);
            end
            OP_DEC: begin
                res_s   = a_in - 8'h01;
                flags_s = set_zn(status_in, a_in - 8'h01);
            end
            OP_CMP: begin
                // Compare always subtracts b_in itself; invert/carry_in do not apply.
                res_s           = a_in;
                flags_s[FLAG_C] = diff_s[8];
                flags_s[FLAG_Z] = (a_in == b_in);
                flags_s[FLAG_N] = diff_s[7];
            end
            OP_BIT: begin
                res_s           = a_in;
                flags_s[FLAG_Z] = zero_flag(a_in & b_in);
                flags_s[FLAG_N] = b_in[7];
                flags_s[FLAG_V] = b_in[6];
            end
            OP_PASS: begin
                res_s   = a_in;
                flags_s = set_zn(status_in, a_in);
            end
            OP_NOP: begin
                valid_s = 1'b0;
            end
            default: begin
                valid_s = 1'b0;
            end
        endcase
    end

    // Output register: capture result and flags on every executed op, hold otherwise.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            dout_r   <= 8'h00;
            status_r <= 8'h00;
            wout_r   <= 1'b0;
        end else if (valid_s) begin
            dout_r   <= res_s;
            status_r <= flags_s;
            wout_r   <= 1'b1;
        end else begin
            wout_r   <= 1'b0;
        end
    end

    assign dout       = dout_r;
    assign status_out = status_r;
    assign wout       = wout_r;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the 6502-style ALU.
module tb_alu;

    logic       clk;
    logic       reset_n;
    logic [7:0] func;
    logic [7:0] status_in;
    logic       carry_in;
    logic       invert;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic [7:0] dout;
    logic       wout;
    logic [7:0] status_out;

    int checks   = 0;
    int failures = 0;

    alu #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .func       (func),
        .status_in  (status_in),
        .carry_in   (carry_in),
        .invert     (invert),
        .a_in       (a_in),
        .b_in       (b_in),
        .dout       (dout),
        .wout       (wout),
        .status_out (status_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // Apply one operation and sample one cycle later, #1 after the edge.
    task automatic run(input logic [7:0] f, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] st, input logic ci, input logic inv);
        func      = f;
        a_in      = a;
        b_in      = b;
        status_in = st;
        carry_in  = ci;
        invert    = inv;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_op(input string tag, input logic [7:0] d, input logic [7:0] s,
                             input logic w);
        check({tag, ".dout"}, dout, d);
        check({tag, ".stat"}, status_out, s);
        check({tag, ".wout"}, {7'd0, wout}, {7'd0, w});
    endtask

    initial begin
        reset_n   = 1'b1;
        func      = 8'h00;
        status_in = 8'h00;
        carry_in  = 1'b0;
        invert    = 1'b0;
        a_in      = 8'h00;
        b_in      = 8'h00;
        #1;
        expect_op("reset", 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;

        // ADD overflow 7F+01
        run(8'h01, 8'h7F, 8'h01, 8'h00, 1'b0, 1'b0);
        expect_op("add_ovf", 8'h80, 8'hC0, 1'b1);
        run(8'h00, 8'h7F, 8'h01, 8'h00, 1'b0, 1'b0);
        expect_op("add_ovf_hold", 8'h80, 8'hC0, 1'b0);

        // ADD carry/zero FF+01
        run(8'h01, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0);
        expect_op("add_cz", 8'h00, 8'h03, 1'b1);

        // SBC 05-06 with C=1 -> FF, borrow
        run(8'h01, 8'h05, 8'h06, 8'h01, 1'b1, 1'b1);
        expect_op("sbc", 8'hFF, 8'h80, 1'b1);

        // CMP equal, then less (invert/carry_in set to show they are ignored)
        run(8'h0B, 8'h10, 8'h10, 8'h00, 1'b0, 1'b0);
        expect_op("cmp_eq", 8'h10, 8'h03, 1'b1);
        run(8'h0B, 8'h0F, 8'h10, 8'h00, 1'b1, 1'b1);
        expect_op("cmp_lt", 8'h0F, 8'h80, 1'b1);

        // Shifts and rotates
        run(8'h05, 8'h81, 8'h55, 8'h00, 1'b0, 1'b0);
        expect_op("asl", 8'h02, 8'h01, 1'b1);
        run(8'h08, 8'h01, 8'h00, 8'h01, 1'b0, 1'b0);
        expect_op("ror", 8'h80, 8'h81, 1'b1);
        run(8'h06, 8'h01, 8'h00, 8'h80, 1'b0, 1'b0);
        expect_op("lsr", 8'h00, 8'h03, 1'b1);
        run(8'h07, 8'h80, 8'h00, 8'h00, 1'b0, 1'b0);
        expect_op("rol_c", 8'h00, 8'h03, 1'b1);
        run(8'h07, 8'h40, 8'h00, 8'h01, 1'b0, 1'b0);
        expect_op("rol_n", 8'h81, 8'h80, 1'b1);

        // Undefined code holds previous result
        run(8'hFF, 8'h12, 8'h34, 8'h00, 1'b0, 1'b0);
        expect_op("undef_hold", 8'h81, 8'h80, 1'b0);

        // INC wrap with I,D,B set and C=1 preserved
        run(8'h09, 8'hFF, 8'h00, 8'h1D, 1'b0, 1'b0);
        expect_op("inc_wrap", 8'h00, 8'h1F, 1'b1);

        // DEC wrap
        run(8'h0A, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        expect_op("dec_wrap", 8'hFF, 8'h80, 1'b1);

        // Logic ops with passthrough bits
        run(8'h02, 8'hF0, 8'h0F, 8'h5C, 1'b0, 1'b0);
        expect_op("and", 8'h00, 8'h5E, 1'b1);
        run(8'h03, 8'h80, 8'h01, 8'h00, 1'b0, 1'b0);
        expect_op("or", 8'h81, 8'h80, 1'b1);
        run(8'h04, 8'hF0, 8'hFF, 8'h22, 1'b0, 1'b0);
        expect_op("xor", 8'h0F, 8'h20, 1'b1);

        // BIT: Z from a&b, N/V from b_in, C passes through
        run(8'h0C, 8'h0F, 8'hC0, 8'h01, 1'b0, 1'b0);
        expect_op("bit", 8'h0F, 8'hC3, 1'b1);

        // PASS
        run(8'h0D, 8'h00, 8'hAA, 8'h80, 1'b0, 1'b0);
        expect_op("pass", 8'h00, 8'h02, 1'b1);

        // Held func re-executes every cycle
        run(8'h01, 8'h01, 8'h01, 8'h00, 1'b0, 1'b0);
        expect_op("add_rep1", 8'h02, 8'h00, 1'b1);
        run(8'h01, 8'h02, 8'h01, 8'h00, 1'b0, 1'b0);
        expect_op("add_rep2", 8'h03, 8'h00, 1'b1);

        // Asynchronous reset mid-operation, with ADD still applied
        #3;
        reset_n = 1'b1;
        #1;
        expect_op("async_rst", 8'h00, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        expect_op("rst_held", 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        run(8'h01, 8'h02, 8'h03, 8'h00, 1'b0, 1'b0);
        expect_op("post_rst", 8'h05, 8'h00, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 8-bit 6502-style arithmetic/logic unit for the NES CPU datapath.
- Takes operands a_in/b_in from the data bus, an operation code from the decoder, and the current processor status.
- Produces a registered result, an updated status byte and a one-cycle done strobe.
- The done strobe tells the top level to write status_out into the STAT register.

Parameters:
- WIDTH, 8, operand/result/status width; only 8 is supported.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous reset, active-HIGH (asserted = 1) despite the codebase name.
- func  input  8  operation code; 0x00 = NOP.
- status_in  input  8  current processor status. Bit 0 C, 1 Z, 2 I, 3 D, 4 B, 5 unused, 6 V, 7 N.
- carry_in  input  1  1 = use status_in[0] as adder carry; 0 = carry is the value of invert.
- invert  input  1  1 = operate on ~b_in instead of b_in (subtract support).
- a_in  input  8  operand A.
- b_in  input  8  operand B.
- dout  output  8  registered result.
- wout  output  1  done strobe; high exactly one cycle per executed operation.
- status_out  output  8  registered updated status.

Behaviour:
- Reset (reset_n=1, asynchronous): dout=0x00, status_out=0x00, wout=0. Reset mid-operation discards the result; wout stays 0 until release.
- Operand B: b = invert ? ~b_in : b_in.
- Carry: cin = carry_in ? status_in[0] : invert.
- Each rising clk with a valid non-NOP func:
  - latch result into dout and the new flags into status_out;
  - set wout=1.
  - Latency is one cycle from func/operands stable to dout/status_out/wout valid.
- func=0x00 or any undefined code:
  - wout=0;
  - dout and status_out hold their previous values.
- func held constant re-executes every cycle, giving one wout per cycle. The decoder clears func to NOP after consuming wout.
- status_out = status_in with only the flags listed below replaced. I, D, B and bit 5 always pass through.
- Z = (result==0); N = result[7] unless stated otherwise.
- Operation codes:
  - 0x01 ADD: {c,r} = a + b + cin. C = c; V = (a[7]==b[7]) && (r[7]!=a[7]). Also Z, N.
  - 0x02 AND, 0x03 OR, 0x04 XOR: r = a op b. Z, N only.
  - 0x05 ASL: r = a<<1, C = a[7].
  - 0x06 LSR: r = a>>1, C = a[0], N = 0.
  - 0x07 ROL: r = {a[6:0], status_in[0]}, C = a[7].
  - 0x08 ROR: r = {status_in[0], a[7:1]}, C = a[0].
  - Shifts and rotates update C, Z, N and ignore b.
  - 0x09 INC: r = a+1, wrapping 0xFF to 0x00. Z, N only; C and V unchanged.
  - 0x0A DEC: r = a-1, wrapping 0x00 to 0xFF. Z, N only.
  - 0x0B CMP: diff = a + ~b_in + 1, ignoring invert and carry_in. C = (a >= b_in) unsigned; Z = (a==b_in); N = diff[7]; dout = a (unchanged); V unchanged.
  - 0x0C BIT: Z = ((a & b_in)==0); N = b_in[7]; V = b_in[6]; dout = a.
  - 0x0D PASS: r = a. Z, N only.
- Boundaries:
  - 0x7F+0x01 gives V=1, N=1.
  - 0xFF+0x01 gives r=0x00, C=1, Z=1.
  - Subtract with borrow: ADD with invert=1, carry_in=1; C=1 means no borrow.

Test Plan:
- Reset: assert reset_n=1 mid-ADD -> dout=0x00, status_out=0x00, wout=0 immediately, without waiting for a clock.
- ADD overflow: func=0x01, a=0x7F, b=0x01, carry_in=0, invert=0 -> next cycle dout=0x80, N=1, V=1, C=0, Z=0, wout=1 for exactly one cycle.
- ADD carry/zero: a=0xFF, b=0x01, cin=0 -> dout=0x00, C=1, Z=1. Then SBC with a=0x05, b_in=0x06, invert=1, carry_in=1, status C=1 -> dout=0xFF, C=0, N=1.
- CMP: a=0x10, b=0x10 -> C=1, Z=1, N=0, dout=0x10. Then a=0x0F, b=0x10 -> C=0, Z=0, N=1.
- Shifts: ASL a=0x81 -> dout=0x02, C=1. ROR a=0x01 with status C=1 -> dout=0x80, C=1, N=1. LSR a=0x01 -> dout=0x00, C=1, Z=1.
- NOP/hold and passthrough:
  - func=0x00 or 0xFF -> wout=0; dout/status_out unchanged.
  - status_in=0x1C with any op -> bits I, D, B preserved in status_out.
  - INC 0xFF -> 0x00, Z=1, C unchanged.
